// File: rtl/stream_pkg.sv
// Shared definitions for valid/ready stream blocks: channel-index width helper
// and common defaults.
package stream_pkg;

  localparam int STREAM_DEFAULT_N     = 4;
  localparam int STREAM_DEFAULT_WIDTH = 8;
  localparam logic STREAM_IDLE        = 1'b0;
  localparam logic STREAM_BUSY        = 1'b1;

  // A single channel still needs a 1-bit index so the ports never collapse.
  function automatic int sel_width(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter with packet lock: a one-hot grant plus
// its encoded index.
module rr_arbiter
  import stream_pkg::*;
#(
  parameter int N     = STREAM_DEFAULT_N,
  parameter int SEL_W = sel_width(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [SEL_W-1:0] ptr_i,
  input  logic             lock_i,
  input  logic [SEL_W-1:0] lk_i,
  output logic [N-1:0]     grant_o,
  output logic [SEL_W-1:0] idx_o
);

  logic [SEL_W:0]   sum_s;
  logic [SEL_W-1:0] cand_s;
  logic             found_s;

  // Locked: only the packet owner may win; otherwise scan from ptr with wrap at N.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    sum_s   = '0;
    cand_s  = '0;
    found_s = 1'b0;
    if (lock_i) begin
      if (req_i[lk_i]) begin
        grant_o[lk_i] = 1'b1;
        idx_o         = lk_i;
      end else begin
        grant_o = '0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        sum_s = {1'b0, ptr_i} + (SEL_W+1)'(k);
        if (sum_s >= (SEL_W+1)'(N)) begin
          sum_s = sum_s - (SEL_W+1)'(N);
        end else begin
          sum_s = sum_s;
        end
        cand_s = sum_s[SEL_W-1:0];
        if (!found_s && req_i[cand_s]) begin
          found_s         = 1'b1;
          grant_o[cand_s] = 1'b1;
          idx_o           = cand_s;
        end else begin
          found_s = found_s;
        end
      end
    end
  end

endmodule

// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream mux with per-packet round-robin arbitration
// and a single registered output stage tagged with the source channel.
module rr_stream_mux
  import stream_pkg::*;
#(
  parameter int N     = STREAM_DEFAULT_N,
  parameter int WIDTH = STREAM_DEFAULT_WIDTH,
  parameter int SEL_W = sel_width(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_valid,
  input  logic [N-1:0]       in_last,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  output logic [SEL_W-1:0]   out_sel,
  input  logic               out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             out_last_q,  out_last_d;
  logic [SEL_W-1:0] out_sel_q,   out_sel_d;
  logic [SEL_W-1:0] ptr_q,       ptr_d;
  logic             lock_q,      lock_d;
  logic [SEL_W-1:0] lk_q,        lk_d;

  logic             load_s;
  logic             xfer_s;
  logic [N-1:0]     grant_s;
  logic [SEL_W-1:0] gidx_s;

  rr_arbiter #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_arb (
    .req_i   (in_valid),
    .ptr_i   (ptr_q),
    .lock_i  (lock_q),
    .lk_i    (lk_q),
    .grant_o (grant_s),
    .idx_o   (gidx_s)
  );

  assign load_s   = !out_valid_q || out_ready;
  // Held low during reset even though the arbiter may already see requests.
  assign in_ready = rst_n ? ({N{load_s}} & grant_s) : '0;
  assign xfer_s   = |(in_valid & in_ready);

  // Next-state for output register, packet lock and round-robin pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    lock_d      = lock_q;
    lk_d        = lk_q;
    if (load_s) begin
      if (xfer_s) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data[int'(gidx_s)*WIDTH +: WIDTH];
        out_last_d  = in_last[gidx_s];
        out_sel_d   = gidx_s;
        if (in_last[gidx_s]) begin
          lock_d = STREAM_IDLE;
          if (gidx_s == SEL_W'(N-1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = gidx_s + SEL_W'(1);
          end
        end else begin
          lock_d = STREAM_BUSY;
          lk_d   = gidx_s;
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
      lock_q      <= STREAM_IDLE;
      lk_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
      lock_q      <= lock_d;
      lk_q        <= lk_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Self-checking bench for rr_stream_mux (N=4, WIDTH=8): directed scenarios
// plus random traffic against a packet-level arbitration model.
module tb_rr_stream_mux;

  localparam int N     = 4;
  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_last;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]     in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic [1:0]       out_sel;
  logic             out_ready;

  int checks = 0;
  int errors = 0;

  // Reference state: what the output register should hold, plus arbitration state.
  logic       m_ov;
  logic [7:0] m_data;
  logic       m_last;
  int         m_sel;
  int         m_ptr;
  logic       m_lock;
  int         m_lk;

  rr_stream_mux #(.N(N), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ov = 1'b0; m_data = 8'h00; m_last = 1'b0; m_sel = 0;
    m_ptr = 0; m_lock = 1'b0; m_lk = 0;
  endtask

  // Winner by the arbitration rules; -1 when nobody may transfer.
  function automatic int model_grant(input logic [3:0] v);
    int c;
    if (m_lock) begin
      if (v[m_lk]) return m_lk;
      return -1;
    end
    for (int k = 0; k < N; k++) begin
      c = (m_ptr + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
    chk({tag, ".out_data"},  32'(out_data),  32'(m_data));
    chk({tag, ".out_last"},  32'(out_last),  32'(m_last));
    chk({tag, ".out_sel"},   32'(out_sel),   32'(m_sel));
  endtask

  // One clock: drive inputs, check in_ready, clock, update model, check outputs.
  task automatic step(input string tag, input logic [3:0] v, input logic [3:0] l,
                      input logic [31:0] d, input logic r);
    int   g;
    logic ld;
    in_valid = v; in_last = l; in_data = d; out_ready = r;
    #2;
    ld = !m_ov || r;
    g  = model_grant(v);
    chk({tag, ".in_ready"}, 32'(in_ready), (ld && g >= 0) ? (32'd1 << g) : 32'd0);
    @(posedge clk);
    if (ld) begin
      if (g >= 0) begin
        m_ov = 1'b1; m_data = d[g*8 +: 8]; m_last = l[g]; m_sel = g;
        if (l[g]) begin
          m_lock = 1'b0; m_ptr = (g + 1) % N;
        end else begin
          m_lock = 1'b1; m_lk = g;
        end
      end else begin
        m_ov = 1'b0;
      end
    end
    #1;
    check_outputs(tag);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 4'hF; in_last = 4'h0; in_data = 32'h0; out_ready = 1'b1;
    model_reset();

    // Reset with every channel requesting
    repeat (3) @(posedge clk);
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    check_outputs("rst");
    rst_n = 1'b1;

    // Round-robin fairness with single-word packets
    for (int i = 0; i < 5; i++) begin
      step("rr", 4'hF, 4'hF, 32'hA3A2A1A0, 1'b1);
      chk("rr.seq_sel",  32'(out_sel),  32'(i % 4));
      chk("rr.seq_data", 32'(out_data), 32'hA0 + 32'(i % 4));
    end

    // Packet lock on channel 2 (ptr=1) with channels 0 and 3 also valid
    step("lock1", 4'hD, 4'h9, {8'($urandom), 8'h11, 8'($urandom), 8'($urandom)}, 1'b1);
    chk("lock1.sel", 32'(out_sel), 32'd2);
    step("lock2", 4'hD, 4'h9, {8'($urandom), 8'h22, 8'($urandom), 8'($urandom)}, 1'b1);
    chk("lock2.data", 32'(out_data), 32'h22);
    chk("lock2.sel", 32'(out_sel), 32'd2);
    step("lock3", 4'hD, 4'hD, {8'($urandom), 8'h33, 8'($urandom), 8'($urandom)}, 1'b1);
    chk("lock3.data", 32'(out_data), 32'h33);
    chk("lock3.last", 32'(out_last), 32'd1);
    step("lock4", 4'hD, 4'hD, $urandom, 1'b1);
    chk("lock4.sel", 32'(out_sel), 32'd3);
    step("lock5", 4'hD, 4'hD, $urandom, 1'b1);
    chk("lock5.sel", 32'(out_sel), 32'd0);

    // Backpressure: four stalled cycles, then drain
    for (int i = 0; i < 4; i++) begin
      step("bp", 4'hF, 4'hF, $urandom, 1'b0);
      chk("bp.ready_zero", 32'(in_ready), 32'd0);
      chk("bp.hold_sel", 32'(out_sel), 32'd0);
    end
    step("bp_go", 4'hF, 4'hF, 32'h44332211, 1'b1);
    chk("bp_go.sel", 32'(out_sel), 32'd1);
    chk("bp_go.data", 32'(out_data), 32'h22);
    step("bp_go2", 4'h0, 4'h0, $urandom, 1'b1);
    chk("bp_go2.drain", 32'(out_valid), 32'd0);

    // Lock bubble on channel 3, then wrap to channel 0
    step("bub1", 4'h8, 4'h0, 32'h5A000000, 1'b1);
    chk("bub1.sel", 32'(out_sel), 32'd3);
    for (int i = 0; i < 2; i++) begin
      step("bub_gap", 4'h7, 4'h7, $urandom, 1'b1);
      chk("bub_gap.ready", 32'(in_ready), 32'd0);
      chk("bub_gap.valid", 32'(out_valid), 32'd0);
    end
    step("bub_end", 4'hF, 4'h8, 32'h6B000000, 1'b1);
    chk("bub_end.sel", 32'(out_sel), 32'd3);
    chk("bub_end.data", 32'(out_data), 32'h6B);
    step("wrap", 4'hF, 4'hF, 32'h00000077, 1'b1);
    chk("wrap.sel", 32'(out_sel), 32'd0);

    // Reset while channel 1 holds the lock
    step("mid1", 4'h2, 4'h0, 32'h00008800, 1'b1);
    chk("mid1.sel", 32'(out_sel), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid.rst_valid", 32'(out_valid), 32'd0);
    chk("mid.rst_ready", 32'(in_ready), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("mid_rel", 4'hB, 4'h0, $urandom, 1'b1);
    chk("mid_rel.sel", 32'(out_sel), 32'd0);

    // Random traffic: packets, bubbles and backpressure
    for (int i = 0; i < 400; i++) begin
      step("rand", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom,
           $urandom_range(0, 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
